data_mem_responder: RTL

Word-addressed data-memory responder serving the single-cycle datapath's load/store port through a valid/ready request channel and a one-cycle response strobe. It replaces the direct RAM hookup where memory must emulate slower storage: it latches one request, inserts a fixed number of wait states, performs the access on internal storage, and reports read data or an address error.

---
 rtl/data_mem_responder_if.sv | 30 +++
 rtl/data_mem_responder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: load/store request channel plus response strobe.
//   master : datapath side, drives req_*, samples rsp_* and req_ready
//   slave  : responder side
//   req_valid/req_ready  valid/ready handshake, one request at a time
//   req_write            1 = store, 0 = load
//   req_addr             byte address
//   req_wdata / req_be   store data and byte-lane strobes
//   rsp_valid            one-cycle response strobe
//   rsp_rdata / rsp_err  load data and address-error flag, held between responses
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory behind a valid/ready port
// that emulates slow storage. One request is latched in IDLE, LATENCY wait
// states follow, the storage access is done on the edge entering RESP and
// rsp_valid pulses for one cycle.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (storage contents are not reset)
//   bus    data_mem_responder_if.slave request/response channel
// Parameters: ADDR_W word-index width (2^ADDR_W words), LATENCY 0..15.
// Build option: DMEM_BYTE_STROBE_EN honours req_be on stores; without it
// every non-error store writes the full word.
module data_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_responder_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  localparam bit       ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [2**ADDR_W];

  req_t              live, cur;
  logic              enter_resp;
  logic              addr_err;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        lane_en;
  logic              do_write;

  assign live = '{write: bus.req_write, addr: bus.req_addr,
                  wdata: bus.req_wdata, be: bus.req_be};

  // With zero latency the access happens on the accept edge itself, so the
  // live request is used instead of the not-yet-latched copy.
  assign cur = (state_q == S_IDLE) ? live : req_q;

  assign enter_resp = (state_q == S_IDLE && bus.req_valid && ZERO_LAT) ||
                      (state_q == S_WAIT && cnt_q == 4'd0);

  assign addr_err = (|cur.addr[1:0]) || (|cur.addr[31:ADDR_W+2]);
  assign idx      = cur.addr[ADDR_W+1:2];

`ifdef DMEM_BYTE_STROBE_EN
  assign lane_en = cur.be;
`else
  assign lane_en = cur.be | 4'hF;
`endif

  // Gated by reset so a zero-latency request presented during reset
  // cannot commit.
  assign do_write = reset && enter_resp && cur.write && !addr_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        req_d   = live;
        cnt_d   = CNT_INIT;
        state_d = ZERO_LAT ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      err_d   = addr_err;
      rdata_d = (addr_err || cur.write) ? 32'h0 : mem_q[idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem_q[idx][8*i +: 8] <= cur.wdata[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule
